// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that lets NREQ requesters share one
// FIFO write port, granting bounded bursts and holding low-priority requesters
// off while the FIFO is almost full.
module fifo_write_arbiter #(
    parameter int unsigned     NREQ         = 4,
    parameter int unsigned     DSIZE        = 8,
    parameter int unsigned     MAX_BURST    = 4,
    parameter logic [NREQ-1:0] LOW_PRI_MASK = NREQ'(4'b1000)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    input  logic                  walmost_full,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int unsigned IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BEATW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [BEATW-1:0]  beat_q, beat_d;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [IDXW-1:0]   idx;
    logic              xfer;

    // Low-priority requesters are held off only at arbitration time.
    assign elig  = req_valid & ~(LOW_PRI_MASK & {NREQ{walmost_full}});
    assign grant = grant_q;
    assign busy  = (state_q == BURST);

    // State register; last starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Arbitration, burst accounting and write-port steering.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beat_d    = beat_q;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        xfer      = 1'b0;
        found     = 1'b0;
        idx       = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned k = 1; k <= NREQ; k++) begin
                    idx = IDXW'((32'(last_q) + k) % NREQ);
                    if (!found && elig[idx]) begin
                        found   = 1'b1;
                        grant_d = NREQ'(1) << idx;
                        last_d  = idx;
                        beat_d  = '0;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // last_q holds the current owner while bursting.
                req_ready[last_q] = ~wfull;
                xfer              = req_valid[last_q] & ~wfull;
                winc              = xfer;
                wdata             = req_data[32'(last_q) * DSIZE +: DSIZE];
                if (!req_valid[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (xfer) begin
                    beat_d = beat_q + BEATW'(1);
                    if (req_last[last_q] || (beat_d == BEATW'(MAX_BURST))) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the FIFO write port.
REQ-002 Parameter DSIZE, default 8, SHALL set the data word width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum beats per grant (range 1..15).
REQ-004 Parameter LOW_PRI_MASK, default 4'b1000, SHALL mark which requesters are low priority (bit i = requester i).
REQ-005 wclk  input  1  SHALL be the single write-domain clock; all state changes on its rising edge.
REQ-006 wrst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 req_valid  input  NREQ  SHALL carry per-requester data-valid.
REQ-008 req_data  input  NREQ*DSIZE  SHALL carry per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-009 req_last  input  NREQ  SHALL mark the final beat of a requester's packet.
REQ-010 req_ready  output  NREQ  SHALL signal that the beat presented by requester i is accepted this cycle.
REQ-011 wfull  input  1  SHALL be the registered full flag from the FIFO write side.
REQ-012 walmost_full  input  1  SHALL be the registered almost-full flag from the FIFO write side.
REQ-013 winc  output  1  SHALL be the FIFO write enable.
REQ-014 wdata  output  DSIZE  SHALL be the FIFO write data.
REQ-015 grant  output  NREQ  SHALL be the registered one-hot owner; all-zero when no owner.
REQ-016 busy  output  1  SHALL be high while the FSM is in BURST.

Function
REQ-017 FSM SHALL have exactly two states: IDLE, BURST.
REQ-018 Eligibility: requester i SHALL be eligible in IDLE when req_valid[i]=1 and not (LOW_PRI_MASK[i]=1 and walmost_full=1).
REQ-019 IDLE: if any requester is eligible, the FSM SHALL choose round-robin, starting at index (last+1) mod NREQ and ascending with wrap; load grant one-hot, set last=winner, clear beat count, go to BURST next cycle (1-cycle arbitration latency).
REQ-020 IDLE: req_ready SHALL be all-zero, winc=0, and the FSM SHALL remain in IDLE if nothing is eligible.
REQ-021 BURST: req_ready[owner] SHALL equal ~wfull; all other req_ready bits 0.
REQ-022 BURST: a transfer occurs when req_valid[owner] and req_ready[owner]; winc SHALL equal transfer, combinationally in the same cycle.
REQ-023 wdata SHALL equal req_data of the owner in BURST, and 0 in IDLE.
REQ-024 Each transfer SHALL increment a 4-bit beat counter.
REQ-025 BURST SHALL exit to IDLE (grant cleared next cycle) on: transfer with req_last[owner]=1; transfer making beat count equal MAX_BURST; or req_valid[owner]=0 in any BURST cycle.
REQ-026 wfull=1 in BURST SHALL stall without exiting: no transfer, counter held, grant held, no timeout.
REQ-027 walmost_full SHALL NOT preempt a low-priority owner already in BURST; it only affects eligibility in IDLE.
REQ-028 A requester continuously valid SHALL receive back-to-back bursts separated by exactly one IDLE cycle.
REQ-029 Requests presented while BURST is active SHALL wait; no request SHALL be lost or reordered within a requester.
REQ-030 At most one req_ready bit SHALL be high in any cycle; winc SHALL never be high while wfull=1.

Reset
REQ-031 wrst=1 SHALL asynchronously force: state IDLE, grant=0, busy=0, beat count=0, last=NREQ-1 (requester 0 wins first); consequently req_ready=0, winc=0, wdata=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; after release the FSM SHALL arbitrate from IDLE with requester 0 first.

Verification
REQ-033 Reset, then all four req_valid high, req_last=0 -> grants in order 0,1,2,3,0, each exactly 4 winc beats, one idle cycle between bursts.
REQ-034 Requester 2 sends 3-beat packet (req_last on beat 3), MAX_BURST=4 -> exactly 3 winc pulses, wdata matches beats, grant clears next cycle.
REQ-035 Requester 1 in BURST, wfull held high 5 cycles after beat 2 -> req_ready[1]=0 and winc=0 for 5 cycles, then beats 3-4 complete, count reaches 4, exit.
REQ-036 walmost_full=1, requesters 1 and 3 valid -> only 1 granted while walmost_full=1; 3 granted once it drops; 3 holding grant keeps it when walmost_full rises mid-burst.
REQ-037 Assert wrst during beat 2 of requester 0's burst -> winc, req_ready, grant, busy all 0 in the same cycle; after release, requesters 0 and 2 valid -> 0 granted first.
REQ-038 All scenarios: checker asserts one-hot-or-zero grant, at most one req_ready, and no winc when wfull=1.
